// File: rtl/gate_accum_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gate_accum_unit_if : handshake/data bundle for gate_accum_unit   (Rev 1.0)
// ----------------------------------------------------------------------------
interface gate_accum_unit_if #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
);
  localparam int CNT_W = $clog2(ACC_LEN);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, y, beat_cnt
  );

  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, y, beat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/gate_accum_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gate_accum_unit : registered 8-way bitwise gate with sticky-OR accumulate (Rev 1.0)
// ----------------------------------------------------------------------------
module gate_accum_unit #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  gate_accum_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_NOTA = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] gate_r;
  logic [WIDTH-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [WIDTH-1:0] fold;
  logic             full;
  logic             ready;
  logic             accept;
  logic             xfer;
  logic             last_beat;
  logic             emit;

  always_comb begin
    gate_r = '0;
    case (bus.op)
      OP_AND:  gate_r = bus.a & bus.b;
      OP_OR:   gate_r = bus.a | bus.b;
      OP_XOR:  gate_r = bus.a ^ bus.b;
      OP_NAND: gate_r = ~(bus.a & bus.b);
      OP_NOR:  gate_r = ~(bus.a | bus.b);
      OP_XNOR: gate_r = ~(bus.a ^ bus.b);
      OP_PASS: gate_r = bus.a;
      OP_NOTA: gate_r = ~bus.a;
      default: gate_r = '0;
    endcase
  end

  // A clear in the same cycle as a beat zeroes the history first, so the beat counts as beat 1.
  always_comb begin
    acc_base  = bus.acc_clr ? '0 : acc;
    cnt_base  = bus.acc_clr ? '0 : cnt;
    fold      = acc_base | gate_r;
    accept    = bus.in_valid && ready;
    xfer      = full && bus.out_ready;
    last_beat = (cnt_base == LAST_CNT);
    emit      = accept && (!bus.acc_en || last_beat);
  end

  always_comb begin
    acc_next = acc_base;
    cnt_next = cnt_base;
    if (accept && bus.acc_en) begin
      if (last_beat) begin
        acc_next = '0;
        cnt_next = '0;
      end else begin
        acc_next = fold;
        cnt_next = cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      y_reg <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (emit) begin
        y_reg <= bus.acc_en ? fold : gate_r;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state; FULL persists while the held word is not taken
  always_comb begin
    state_next = ST_IDLE;
    if (emit || (full && !xfer)) begin
      state_next = ST_FULL;
    end else if (cnt_next != '0) begin
      state_next = ST_ACCUM;
    end else begin
      state_next = ST_IDLE;
    end
  end

  // FSM: outputs
  always_comb begin
    full  = (state == ST_FULL);
    ready = !full || bus.out_ready;
  end

  assign bus.out_valid = full;
  assign bus.in_ready  = ready;
  assign bus.y         = y_reg;
  assign bus.beat_cnt  = cnt;

endmodule
`default_nettype wire

// File: tb/tb_gate_accum_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gate_accum_unit : directed self-checking bench for gate_accum_unit (Rev 1.0)
// ----------------------------------------------------------------------------
module tb_gate_accum_unit;
  localparam int WIDTH   = 8;
  localparam int ACC_LEN = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gate_accum_unit_if #(.WIDTH(WIDTH), .ACC_LEN(ACC_LEN)) bus ();

  gate_accum_unit #(.WIDTH(WIDTH), .ACC_LEN(ACC_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [2:0] op, input logic acc_en);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.op       = op;
    bus.acc_en   = acc_en;
  endtask

  logic [7:0] op_exp [8];

  initial begin
    op_exp = '{8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5, 8'h5A};
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.acc_en    = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", 32'(bus.y), 32'h00);
    chk("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // All eight gate ops back to back, one result per cycle
    bus.b = 8'h3C;
    for (int k = 0; k < 8; k++) begin
      beat(8'hA5, 3'(k), 1'b0);
      #1;
      chk($sformatf("op%0d_in_ready", k), 32'(bus.in_ready), 32'd1);
      tick();
      chk($sformatf("op%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("op%0d_y", k), 32'(bus.y), 32'(op_exp[k]));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("ops_drained", 32'(bus.out_valid), 32'd0);

    // Accumulate 01,02,04,08 with PASS
    beat(8'h01, 3'd6, 1'b1);
    tick();
    chk("acc1_cnt", 32'(bus.beat_cnt), 32'd1);
    chk("acc1_valid", 32'(bus.out_valid), 32'd0);
    bus.a = 8'h02;
    tick();
    chk("acc2_cnt", 32'(bus.beat_cnt), 32'd2);
    chk("acc2_valid", 32'(bus.out_valid), 32'd0);
    bus.a = 8'h04;
    tick();
    chk("acc3_cnt", 32'(bus.beat_cnt), 32'd3);
    chk("acc3_valid", 32'(bus.out_valid), 32'd0);
    bus.a = 8'h08;
    tick();
    chk("acc4_cnt", 32'(bus.beat_cnt), 32'd0);
    chk("acc4_valid", 32'(bus.out_valid), 32'd1);
    chk("acc4_y", 32'(bus.y), 32'h0F);
    bus.in_valid = 1'b0;
    tick();
    chk("acc_single_pulse", 32'(bus.out_valid), 32'd0);

    // Backpressure holds y and blocks the next beat
    bus.out_ready = 1'b0;
    beat(8'h11, 3'd6, 1'b0);
    tick();
    chk("bp_first_y", 32'(bus.y), 32'h11);
    bus.a = 8'h22;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d_y", k), 32'(bus.y), 32'h11);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_reload_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_reload_y", 32'(bus.y), 32'h22);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-burst with a pending output
    beat(8'h01, 3'd6, 1'b1);
    tick();
    tick();
    chk("mid_cnt2", 32'(bus.beat_cnt), 32'd2);
    bus.out_ready = 1'b0;
    beat(8'h77, 3'd6, 1'b0);
    tick();
    chk("mid_pending_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_cnt_untouched", 32'(bus.beat_cnt), 32'd2);
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_y", 32'(bus.y), 32'h00);
    chk("async_rst_cnt", 32'(bus.beat_cnt), 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Fresh burst, interleaved plain beat, then clear-with-beat
    beat(8'hF0, 3'd6, 1'b1);
    tick();
    chk("fresh_cnt1", 32'(bus.beat_cnt), 32'd1);
    tick();
    chk("fresh_cnt2", 32'(bus.beat_cnt), 32'd2);
    beat(8'h55, 3'd6, 1'b0);
    tick();
    chk("ilv_y", 32'(bus.y), 32'h55);
    chk("ilv_cnt", 32'(bus.beat_cnt), 32'd2);
    beat(8'h01, 3'd6, 1'b1);
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    chk("clr_beat_cnt", 32'(bus.beat_cnt), 32'd1);
    chk("clr_beat_valid", 32'(bus.out_valid), 32'd0);
    bus.a = 8'h00;
    tick();
    chk("clr_cnt2", 32'(bus.beat_cnt), 32'd2);
    tick();
    chk("clr_cnt3", 32'(bus.beat_cnt), 32'd3);
    chk("clr_no_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("clr_emit_valid", 32'(bus.out_valid), 32'd1);
    chk("clr_emit_y", 32'(bus.y), 32'h01);
    chk("clr_emit_cnt", 32'(bus.beat_cnt), 32'd0);
    bus.in_valid = 1'b0;
    tick();

    // Clear alone, then a full burst of NOT-a beats (~FC = 03)
    beat(8'hFF, 3'd6, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    chk("clr_only_cnt", 32'(bus.beat_cnt), 32'd0);
    chk("clr_only_valid", 32'(bus.out_valid), 32'd0);
    beat(8'hFC, 3'd7, 1'b1);
    tick();
    tick();
    tick();
    chk("nota_no_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("nota_emit_valid", 32'(bus.out_valid), 32'd1);
    chk("nota_emit_y", 32'(bus.y), 32'h03);
    bus.in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/gate_accum_unit.md
Name: gate_accum_unit

Overview:
Parametrised, registered successor to the two-input OR primitive. Applies one of eight selectable bitwise gate operations to two WIDTH-bit operands, with a valid/ready handshake on both sides and a one-entry output register. An optional sticky-OR accumulate mode folds ACC_LEN consecutive results into a single output word. Used as the generic gate/flag-collection stage in the lab datapath.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
ACC_LEN, 4, accepted accumulate beats per emitted word (>=2)
CNT_W, $clog2(ACC_LEN), derived localparam, beat counter width

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat offered
in_ready  output  1  unit can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  gate select, sampled with the beat
acc_en  input  1  beat belongs to an accumulate burst, sampled with the beat
acc_clr  input  1  synchronous clear of accumulator and beat counter
out_valid  output  1  y holds a result
out_ready  input  1  downstream accepts y
y  output  WIDTH  registered result
beat_cnt  output  CNT_W  accumulate beats held, 0..ACC_LEN-1

Behaviour:
- Reset (async, rst=1): out_valid=0, y=0, beat_cnt=0, accumulator=0. in_ready=1 once the unit leaves reset. Reset mid-burst discards the partial accumulation and any un-taken output.
- Op codes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS a, 7 NOT a. The gate result is r. For codes 6 and 7, b is ignored.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Output-side transfer = out_valid && out_ready. While out_valid=1 and out_ready=0, y and out_valid hold stable.
- A transfer and an accept in the same cycle are legal. The register reloads, giving full throughput.
- Non-accumulate beat (acc_en=0), on accept:
  - next cycle y=r and out_valid=1 (latency 1).
  - The accumulator and beat_cnt are untouched, so a burst may be interleaved with such beats.
- Accumulate beat (acc_en=1), on accept, with v = acc | r:
  - if beat_cnt < ACC_LEN-1: acc <= v; beat_cnt++. No output is produced, and out_valid is unchanged apart from any transfer.
  - if beat_cnt == ACC_LEN-1: y <= v; out_valid <= 1; acc <= 0; beat_cnt <= 0.
- acc_clr=1: acc <= 0 and beat_cnt <= 0.
  - If a beat is accepted in the same cycle, it is processed with acc treated as 0 and beat_cnt as 0. The clear wins first, then the beat counts as beat 1.
  - acc_clr never affects y or out_valid.
- FSM, derived from beat_cnt and out_valid:
  - IDLE (cnt=0, !out_valid)
  - ACCUM (cnt>0, !out_valid)
  - FULL (out_valid, any cnt)
  - FULL -> IDLE/ACCUM on transfer without a new emitting accept.
  - IDLE/ACCUM -> FULL on an emitting accept.
- Operand and result widths are exactly WIDTH. There is no carry and no extension.

Test Plan:
- Reset: drive a burst to beat_cnt=2, hold out_valid=1, assert rst asynchronously between edges -> out_valid=0, y=0, beat_cnt=0 immediately. After release, a new burst starts at count 0.
- Ops (WIDTH=8, a=8'hA5, b=8'h3C, acc_en=0, out_ready=1), op 0..7 on successive cycles -> y = 24, BD, 99, DB, 42, 66, A5, 5A, each one cycle after accept, with one result per cycle.
- Accumulate (ACC_LEN=4, op=PASS, a=01,02,04,08) -> beat_cnt 1,2,3,0 and a single out_valid pulse with y=8'h0F after the 4th accept, with no earlier output.
- Backpressure: result pending, out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, y stable, no accept. Raise out_ready -> old y transfers and the next beat is accepted in the same cycle.
- Clear and interleave:
  - 2 accumulate beats (a=F0), then acc_clr with an accepted beat a=01, then 3 more beats a=00 -> output y=8'h01, showing the earlier F0 was discarded.
  - A non-accumulate beat a=0x55 mid-burst -> y=55 and beat_cnt unchanged.
